// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one data access per req, with lane steering, strobes, load extension and misalign faults (optional LSU_TIMEOUT_EN watchdog).
// Latency: bus_req the cycle after accept, done the cycle after bus_ack; faults pulse the cycle after accept.
// Backpressure: busy stalls the core while an access is outstanding; req is ignored unless idle.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  load_width,
  input  logic [2:0]  store_width,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state;
  logic [2:0]  widthQ;
  logic [1:0]  offQ;

  logic [1:0]  accSize;
  logic        widthOk;
  logic        misaligned;
  logic [3:0]  laneStrb;
  logic [31:0] laneData;
  logic [31:0] shifted;
  logic [31:0] loadData;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] waitCnt;
`endif

  // Access size: 0=byte, 1=half, 2=word; LWU aliases LW on a 32-bit core.
  always_comb begin
    widthOk = 1'b1;
    accSize = 2'd0;
    if (mem_write_en) begin
      case (store_width)
        3'd0:    accSize = 2'd0;
        3'd1:    accSize = 2'd1;
        3'd2:    accSize = 2'd2;
        default: widthOk = 1'b0;
      endcase
    end else begin
      case (load_width)
        3'd0, 3'd4: accSize = 2'd0;
        3'd1, 3'd5: accSize = 2'd1;
        3'd2, 3'd6: accSize = 2'd2;
        default:    widthOk = 1'b0;
      endcase
    end
    misaligned = ((accSize == 2'd1) && addr[0]) || ((accSize == 2'd2) && (addr[1:0] != 2'b00));
    case (accSize)
      2'd0: begin
        laneStrb = 4'b0001 << addr[1:0];
        laneData = {4{wdata[7:0]}};
      end
      2'd1: begin
        laneStrb = addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wdata[15:0]}};
      end
      default: begin
        laneStrb = 4'b1111;
        laneData = wdata;
      end
    endcase
  end

  always_comb begin
    shifted = bus_rdata >> {offQ, 3'b000};
    case (widthQ)
      3'd0:    loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    loadData = {24'h0, shifted[7:0]};
      3'd5:    loadData = {16'h0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
      widthQ    <= 3'd0;
      offQ      <= 2'd0;
`ifdef LSU_TIMEOUT_EN
      waitCnt   <= '0;
`endif
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req && (mem_read_en || mem_write_en)) begin
            busy <= 1'b1;
            if ((mem_read_en && mem_write_en) || !widthOk || misaligned) begin
              state <= ERR;
              fault <= 1'b1;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= mem_write_en;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= mem_write_en ? laneStrb : 4'h0;
              bus_wdata <= laneData;
              widthQ    <= load_width;
              offQ      <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
              waitCnt   <= '0;
`endif
            end
          end
        end
        REQ: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (!bus_we) rdata <= loadData;
          end
`ifdef LSU_TIMEOUT_EN
          else if (waitCnt == CW'(TIMEOUT - 1)) begin
            state   <= ERR;
            bus_req <= 1'b0;
            fault   <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: stores, loads, faults, busy handling, reset abort and optional timeout.
module tb_lsu_mem_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [2:0]  load_width = 3'd0;
  logic [2:0]  store_width = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .load_width(load_width), .store_width(store_width),
    .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Load vectors: width, address, bus word, expected extended result.
  logic [2:0]  ldW [6] = '{3'd0, 3'd4, 3'd0, 3'd5, 3'd2, 3'd6};
  logic [31:0] ldA [6] = '{32'h2002, 32'h2002, 32'h2003, 32'h2000, 32'h2000, 32'h2004};
  logic [31:0] ldR [6] = '{32'h12F45678, 32'h12F45678, 32'h80011234, 32'h80011234, 32'h80011234, 32'hCAFEF00D};
  logic [31:0] ldE [6] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFFFF80, 32'h00001234, 32'h80011234, 32'hCAFEF00D};
  logic [31:0] ldBA [6] = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2004};

  // Fault vectors: read enable, write enable, load width, store width, address.
  logic        fRe [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        fWe [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  fLw [6] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd7, 3'd1};
  logic [2:0]  fSw [6] = '{3'd2, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0};
  logic [31:0] fA  [6] = '{32'h3002, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h2001};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic re, input logic we, input logic [2:0] lw,
                       input logic [2:0] sw, input logic [31:0] a, input logic [31:0] wd);
    mem_read_en  = re;
    mem_write_en = we;
    load_width   = lw;
    store_width  = sw;
    addr         = a;
    wdata        = wd;
    req          = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    nCmp++;
    if ({busy, done, fault, bus_req, bus_we} !== 5'b0) begin
      nBad++; $display("FAIL reset_flags got %b required %b", {busy, done, fault, bus_req, bus_we}, 5'b0);
    end
    nCmp++;
    if (bus_wstrb !== 4'h0) begin
      nBad++; $display("FAIL reset_wstrb got %h required 0", bus_wstrb);
    end
    nCmp++;
    if ({rdata, bus_addr, bus_wdata} !== 96'h0) begin
      nBad++; $display("FAIL reset_data got %h %h %h required 0", rdata, bus_addr, bus_wdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stores();
    // SB with detailed cycle timing
    issue(1'b0, 1'b1, 3'd0, 3'd0, 32'h1003, 32'h000000A5);
    step();
    req = 1'b0;
    nCmp++;
    if ({bus_req, bus_we, busy, done} !== 4'b1110) begin
      nBad++; $display("FAIL sb_ctrl got %b required %b", {bus_req, bus_we, busy, done}, 4'b1110);
    end
    nCmp++;
    if (bus_addr !== 32'h1000) begin
      nBad++; $display("FAIL sb_addr got %h required %h", bus_addr, 32'h1000);
    end
    nCmp++;
    if (bus_wstrb !== 4'b1000) begin
      nBad++; $display("FAIL sb_wstrb got %b required %b", bus_wstrb, 4'b1000);
    end
    nCmp++;
    if (bus_wdata !== 32'hA5A5A5A5) begin
      nBad++; $display("FAIL sb_wdata got %h required %h", bus_wdata, 32'hA5A5A5A5);
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    nCmp++;
    if ({done, bus_req, busy} !== 3'b101) begin
      nBad++; $display("FAIL sb_done got %b required %b", {done, bus_req, busy}, 3'b101);
    end
    nCmp++;
    if (rdata !== 32'hCAFEF00D) begin
      nBad++; $display("FAIL sb_rdata_held got %h required %h", rdata, 32'hCAFEF00D);
    end
    step();
    nCmp++;
    if ({done, busy} !== 2'b00) begin
      nBad++; $display("FAIL sb_idle got %b required %b", {done, busy}, 2'b00);
    end

    // SH upper half
    issue(1'b0, 1'b1, 3'd0, 3'd1, 32'h1002, 32'hDEADBEEF);
    step();
    req = 1'b0;
    nCmp++;
    if ({bus_wstrb, bus_wdata, bus_addr} !== {4'b1100, 32'hBEEFBEEF, 32'h1000}) begin
      nBad++; $display("FAIL sh_bus got %b %h %h required 1100 beefbeef 00001000", bus_wstrb, bus_wdata, bus_addr);
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();

    // SW aligned
    issue(1'b0, 1'b1, 3'd0, 3'd2, 32'h1004, 32'h11223344);
    step();
    req = 1'b0;
    nCmp++;
    if ({bus_wstrb, bus_wdata, bus_addr} !== {4'b1111, 32'h11223344, 32'h1004}) begin
      nBad++; $display("FAIL sw_bus got %b %h %h required 1111 11223344 00001004", bus_wstrb, bus_wdata, bus_addr);
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_loads();
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, ldW[i], 3'd0, ldA[i], 32'h0);
      step();
      req = 1'b0;
      nCmp++;
      if ({bus_req, bus_we, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 4'h0, ldBA[i]}) begin
        nBad++; $display("FAIL load%0d_bus got %b %b %b %h required 1 0 0000 %h", i, bus_req, bus_we, bus_wstrb, bus_addr, ldBA[i]);
      end
      bus_rdata = ldR[i];
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
      nCmp++;
      if ({done, rdata} !== {1'b1, ldE[i]}) begin
        nBad++; $display("FAIL load%0d_rdata got done=%b %h required done=1 %h", i, done, rdata, ldE[i]);
      end
      step();
    end
  endtask

  task automatic test_wait_states();
    logic eBusy, eDone;
    issue(1'b1, 1'b0, 3'd1, 3'd0, 32'h2002, 32'h0);
    step();
    req = 1'b0;
    bus_rdata = 32'h80011234;
    for (int c = 1; c <= 6; c++) begin
      eBusy = (c <= 5);
      eDone = (c == 5);
      bus_ack = (c == 4);
      nCmp++;
      if ({busy, done} !== {eBusy, eDone}) begin
        nBad++; $display("FAIL lh_wait_c%0d got busy=%b done=%b required busy=%b done=%b", c, busy, done, eBusy, eDone);
      end
      if (c == 5) begin
        nCmp++;
        if (rdata !== 32'hFFFF8001) begin
          nBad++; $display("FAIL lh_wait_rdata got %h required %h", rdata, 32'hFFFF8001);
        end
      end
      step();
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_faults();
    for (int i = 0; i < 6; i++) begin
      issue(fRe[i], fWe[i], fLw[i], fSw[i], fA[i], 32'h55);
      step();
      req = 1'b0;
      nCmp++;
      if ({fault, busy, bus_req, done} !== 4'b1100) begin
        nBad++; $display("FAIL fault%0d_pulse got %b required %b", i, {fault, busy, bus_req, done}, 4'b1100);
      end
      step();
      nCmp++;
      if ({fault, busy, bus_req} !== 3'b000) begin
        nBad++; $display("FAIL fault%0d_after got %b required %b", i, {fault, busy, bus_req}, 3'b000);
      end
    end
    // req with no enable, and a stray ack, must both be ignored
    issue(1'b0, 1'b0, 3'd2, 3'd2, 32'h0, 32'h0);
    bus_ack = 1'b1;
    step();
    req = 1'b0;
    step();
    bus_ack = 1'b0;
    nCmp++;
    if ({busy, done, fault, bus_req} !== 4'b0000) begin
      nBad++; $display("FAIL idle_ignore got %b required %b", {busy, done, fault, bus_req}, 4'b0000);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'd2, 3'd0, 32'h2000, 32'h0);
    step();
    // req held high with new store operands while busy
    issue(1'b0, 1'b1, 3'd0, 3'd2, 32'h4000, 32'h99887766);
    bus_rdata = 32'h0BADF00D;
    bus_ack = 1'b1;
    nCmp++;
    if ({bus_addr, bus_we} !== {32'h2000, 1'b0}) begin
      nBad++; $display("FAIL b2b_stable got %h we=%b required 00002000 we=0", bus_addr, bus_we);
    end
    step();
    bus_ack = 1'b0;
    nCmp++;
    if ({done, rdata} !== {1'b1, 32'h0BADF00D}) begin
      nBad++; $display("FAIL b2b_done got done=%b %h required done=1 0badf00d", done, rdata);
    end
    step();
    nCmp++;
    if ({busy, bus_req} !== 2'b00) begin
      nBad++; $display("FAIL b2b_gap got busy=%b bus_req=%b required 0 0", busy, bus_req);
    end
    step();
    req = 1'b0;
    nCmp++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b1, 32'h4000}) begin
      nBad++; $display("FAIL b2b_second got %b %b %h required 1 1 00004000", bus_req, bus_we, bus_addr);
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'd2, 3'd0, 32'h2000, 32'h0);
    step();
    req = 1'b0;
    rst = 1'b1;
    step();
    nCmp++;
    if ({bus_req, busy} !== 2'b00) begin
      nBad++; $display("FAIL rstmid_abort got bus_req=%b busy=%b required 0 0", bus_req, busy);
    end
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    step();
    step();
    bus_ack = 1'b0;
    nCmp++;
    if ({done, rdata} !== {1'b0, 32'h0}) begin
      nBad++; $display("FAIL rstmid_no_done got done=%b %h required done=0 00000000", done, rdata);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    issue(1'b1, 1'b0, 3'd2, 3'd0, 32'h2000, 32'h0);
    step();
    req = 1'b0;
    step();
    step();
    step();
    nCmp++;
    if ({bus_req, fault} !== 2'b10) begin
      nBad++; $display("FAIL to_cycle4 got bus_req=%b fault=%b required 1 0", bus_req, fault);
    end
    step();
    nCmp++;
    if ({fault, bus_req, done, busy} !== 4'b1001) begin
      nBad++; $display("FAIL to_fault got %b required %b", {fault, bus_req, done, busy}, 4'b1001);
    end
    step();
    nCmp++;
    if ({fault, busy} !== 2'b00) begin
      nBad++; $display("FAIL to_idle got %b required %b", {fault, busy}, 2'b00);
    end
    // ack on the 4th REQ cycle wins over the timeout
    issue(1'b1, 1'b0, 3'd2, 3'd0, 32'h2000, 32'h0);
    step();
    req = 1'b0;
    step();
    step();
    step();
    bus_rdata = 32'h13572468;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    nCmp++;
    if ({done, fault, rdata} !== {2'b10, 32'h13572468}) begin
      nBad++; $display("FAIL to_ack_wins got done=%b fault=%b %h required 1 0 13572468", done, fault, rdata);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_faults();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
